// File: rtl/multicycle_sequencer.sv
// Stage sequencer for the multi-cycle RV32I core: walks FETCH..WRITEBACK per opcode
// class, stalls on memory handshakes, traps faults/timeouts into HALT and counts retirements.
module multicycle_sequencer #(
  parameter bit SKIP_MEM    = 1'b1,
  parameter int TIMEOUT_W   = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opcode,
  input  logic                instr_valid,
  input  logic                mem_ready,
  input  logic                illegal_read_address,
  input  logic                illegal_write_address,
  input  logic                halt_req,
  input  logic                resume,
  output logic [2:0]          stage,
  output logic                ir_en,
  output logic                pc_en,
  output logic                reg_wr_en,
  output logic                mem_req,
  output logic                mem_we,
  output logic                halted,
  output logic [1:0]          fault,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd7
  } stage_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
  localparam logic [1:0] FAULT_ADDR    = 2'd2;
  localparam logic [1:0] FAULT_TIMEOUT = 2'd3;

  stage_t                stage_reg, stage_next;
  logic [TIMEOUT_W-1:0]  wait_reg, wait_next;
  logic [1:0]            fault_reg, fault_next;
  logic [RETIRE_W-1:0]   retired_reg, retired_next;

  logic ir_en_raw, pc_en_raw, reg_wr_raw, mem_req_raw, mem_we_raw;
  logic is_load, is_store, is_mem, is_wb, timed_out;

  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_mem    = is_load | is_store;
  assign is_wb     = (opcode == OPC_OP)  || (opcode == OPC_OP_IMM) || (opcode == OPC_LUI) ||
                     (opcode == OPC_AUIPC) || (opcode == OPC_JAL)  || (opcode == OPC_JALR);
  assign timed_out = (wait_reg == TIMEOUT_W'(MEM_TIMEOUT));

  always_comb begin
    stage_next  = stage_reg;
    wait_next   = wait_reg;
    fault_next  = fault_reg;
    ir_en_raw   = 1'b0;
    pc_en_raw   = 1'b0;
    reg_wr_raw  = 1'b0;
    mem_req_raw = 1'b0;
    mem_we_raw  = 1'b0;

    case (stage_reg)
      ST_FETCH: begin
        mem_req_raw = 1'b1;
        if (!mem_ready) begin
          if (timed_out) begin
            fault_next = FAULT_TIMEOUT;
            stage_next = ST_HALT;
          end else begin
            wait_next = wait_reg + TIMEOUT_W'(1);
          end
        end else if (illegal_read_address) begin
          fault_next = FAULT_ADDR;
          stage_next = ST_HALT;
        end else begin
          ir_en_raw  = 1'b1;
          stage_next = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (!instr_valid) begin
          fault_next = FAULT_ILLEGAL;
          stage_next = ST_HALT;
        end else begin
          stage_next = ST_EXECUTE;
        end
      end

      ST_EXECUTE: begin
        stage_next = (is_mem || !SKIP_MEM) ? ST_MEMORY : ST_WRITEBACK;
      end

      ST_MEMORY: begin
        // Non-memory classes only land here in legacy timing; they pass straight through.
        if (is_mem) begin
          mem_req_raw = 1'b1;
          mem_we_raw  = is_store;
          if (!mem_ready) begin
            if (timed_out) begin
              fault_next = FAULT_TIMEOUT;
              stage_next = ST_HALT;
            end else begin
              wait_next = wait_reg + TIMEOUT_W'(1);
            end
          end else if (is_store ? illegal_write_address : illegal_read_address) begin
            fault_next = FAULT_ADDR;
            stage_next = ST_HALT;
          end else if (is_store) begin
            pc_en_raw  = 1'b1;
            stage_next = halt_req ? ST_HALT : ST_FETCH;
          end else begin
            stage_next = ST_WRITEBACK;
          end
        end else begin
          stage_next = ST_WRITEBACK;
        end
      end

      ST_WRITEBACK: begin
        pc_en_raw  = 1'b1;
        reg_wr_raw = is_load | is_wb;
        stage_next = halt_req ? ST_HALT : ST_FETCH;
      end

      ST_HALT: begin
        if (resume) begin
          fault_next = FAULT_NONE;
          stage_next = ST_FETCH;
        end
      end

      default: begin
        stage_next = ST_HALT;
      end
    endcase

    if (stage_next != stage_reg) begin
      wait_next = '0;
    end
  end

  assign retired_next = pc_en_raw ? (retired_reg + RETIRE_W'(1)) : retired_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_reg   <= ST_FETCH;
      wait_reg    <= '0;
      fault_reg   <= FAULT_NONE;
      retired_reg <= '0;
    end else begin
      stage_reg   <= stage_next;
      wait_reg    <= wait_next;
      fault_reg   <= fault_next;
      retired_reg <= retired_next;
    end
  end

  // Gating with rst kills an in-flight memory request the instant reset asserts.
  assign ir_en     = ir_en_raw   & rst;
  assign pc_en     = pc_en_raw   & rst;
  assign reg_wr_en = reg_wr_raw  & rst;
  assign mem_req   = mem_req_raw & rst;
  assign mem_we    = mem_we_raw  & rst;

  assign stage   = stage_reg;
  assign halted  = (stage_reg == ST_HALT);
  assign fault   = fault_reg;
  assign retired = retired_reg;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: a SKIP_MEM=1 instance and a legacy
// SKIP_MEM=0 instance share stimulus; expected values are hand-computed.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        instr_valid, mem_ready, illegal_read_address, illegal_write_address;
  logic        halt_req, resume;

  logic [2:0]  stage, l_stage;
  logic        ir_en, pc_en, reg_wr_en, mem_req, mem_we, halted;
  logic        l_ir_en, l_pc_en, l_reg_wr_en, l_mem_req, l_mem_we, l_halted;
  logic [1:0]  fault, l_fault;
  logic [31:0] retired, l_retired;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multicycle_sequencer #(.SKIP_MEM(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .instr_valid(instr_valid),
    .mem_ready(mem_ready), .illegal_read_address(illegal_read_address),
    .illegal_write_address(illegal_write_address), .halt_req(halt_req), .resume(resume),
    .stage(stage), .ir_en(ir_en), .pc_en(pc_en), .reg_wr_en(reg_wr_en),
    .mem_req(mem_req), .mem_we(mem_we), .halted(halted), .fault(fault), .retired(retired)
  );

  multicycle_sequencer #(.SKIP_MEM(1'b0)) dut_legacy (
    .clk(clk), .rst(rst), .opcode(opcode), .instr_valid(instr_valid),
    .mem_ready(mem_ready), .illegal_read_address(illegal_read_address),
    .illegal_write_address(illegal_write_address), .halt_req(halt_req), .resume(resume),
    .stage(l_stage), .ir_en(l_ir_en), .pc_en(l_pc_en), .reg_wr_en(l_reg_wr_en),
    .mem_req(l_mem_req), .mem_we(l_mem_we), .halted(l_halted), .fault(l_fault),
    .retired(l_retired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    opcode = 7'h13; instr_valid = 1'b1; mem_ready = 1'b1;
    illegal_read_address = 1'b0; illegal_write_address = 1'b0;
    halt_req = 1'b0; resume = 1'b0;

    // Reset state: FETCH, enables gated off
    #1;
    check("rst_stage", stage, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_ir_en", ir_en, 0);
    check("rst_fault", fault, 0);
    check("rst_retired", retired, 0);
    $display("[TB] reset state checked");

    // OP-IMM, mem_ready always 1; both instances in parallel
    #11; rst = 1'b1; #1;
    check("opi_f_stage", stage, 0);
    check("opi_f_ir_en", ir_en, 1);
    check("opi_f_mem_req", mem_req, 1);
    tick();
    check("opi_d_stage", stage, 1);
    check("opi_d_ir_en", ir_en, 0);
    tick();
    check("opi_e_stage", stage, 2);
    check("opi_e_leg_stage", l_stage, 2);
    tick();
    check("opi_wb_stage", stage, 4);
    check("opi_wb_pc_en", pc_en, 1);
    check("opi_wb_reg_wr", reg_wr_en, 1);
    check("opi_wb_retired", retired, 0);
    check("opi_leg_mem_stage", l_stage, 3);
    check("opi_leg_mem_req", l_mem_req, 0);
    check("opi_leg_mem_pc_en", l_pc_en, 0);
    tick();
    check("opi_next_stage", stage, 0);
    check("opi_retired", retired, 1);
    check("opi_leg_wb_stage", l_stage, 4);
    check("opi_leg_wb_pc_en", l_pc_en, 1);
    check("opi_leg_wb_reg_wr", l_reg_wr_en, 1);
    tick();
    check("opi_leg_next_stage", l_stage, 0);
    check("opi_leg_retired", l_retired, 1);
    $display("[TB] OP-IMM sequence checked");

    // STORE with three wait cycles in MEMORY
    pulse_reset();
    opcode = 7'h23; mem_ready = 1'b1; #1;
    tick();
    check("st_d_stage", stage, 1);
    tick();
    check("st_e_stage", stage, 2);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("st_wait_stage", stage, 3);
      check("st_wait_mem_req", mem_req, 1);
      check("st_wait_mem_we", mem_we, 1);
      check("st_wait_pc_en", pc_en, 0);
      check("st_wait_reg_wr", reg_wr_en, 0);
      tick();
    end
    mem_ready = 1'b1; #1;
    check("st_rdy_stage", stage, 3);
    check("st_rdy_mem_req", mem_req, 1);
    check("st_rdy_mem_we", mem_we, 1);
    check("st_rdy_pc_en", pc_en, 1);
    check("st_rdy_reg_wr", reg_wr_en, 0);
    tick();
    check("st_next_stage", stage, 0);
    check("st_retired", retired, 1);
    $display("[TB] STORE with wait states checked");

    // FETCH timeout: 16 wait cycles then HALT with fault 3
    mem_ready = 1'b0; #1;
    for (int i = 0; i < 16; i++) begin
      check("to_wait_stage", stage, 0);
      check("to_wait_ir_en", ir_en, 0);
      tick();
    end
    check("to_stage", stage, 7);
    check("to_fault", fault, 3);
    check("to_halted", halted, 1);
    check("to_mem_req", mem_req, 0);
    check("to_retired", retired, 1);
    halt_req = 1'b1; resume = 1'b1;
    tick();
    resume = 1'b0; halt_req = 1'b0; #1;
    check("res_stage", stage, 0);
    check("res_fault", fault, 0);
    check("res_halted", halted, 0);
    check("res_retired", retired, 1);
    $display("[TB] fetch timeout and resume checked");

    // Illegal instruction in DECODE
    pulse_reset();
    opcode = 7'h13; mem_ready = 1'b1; instr_valid = 1'b0; #1;
    tick();
    check("ill_d_stage", stage, 1);
    check("ill_d_pc_en", pc_en, 0);
    tick();
    check("ill_stage", stage, 7);
    check("ill_fault", fault, 1);
    check("ill_pc_en", pc_en, 0);
    check("ill_retired", retired, 0);
    instr_valid = 1'b1;
    $display("[TB] illegal instruction checked");

    // LOAD hitting an illegal read address
    pulse_reset();
    opcode = 7'h03; mem_ready = 1'b1; #1;
    tick();
    tick();
    tick();
    illegal_read_address = 1'b1; #1;
    check("ld_m_stage", stage, 3);
    check("ld_m_mem_req", mem_req, 1);
    check("ld_m_mem_we", mem_we, 0);
    check("ld_m_reg_wr", reg_wr_en, 0);
    check("ld_m_pc_en", pc_en, 0);
    tick();
    illegal_read_address = 1'b0; #1;
    check("ld_stage", stage, 7);
    check("ld_fault", fault, 2);
    check("ld_reg_wr", reg_wr_en, 0);
    check("ld_retired", retired, 0);
    $display("[TB] load address fault checked");

    // halt_req raised during EXECUTE of an OP takes effect at the boundary
    pulse_reset();
    opcode = 7'h33; mem_ready = 1'b1; #1;
    tick();
    tick();
    halt_req = 1'b1; #1;
    check("hr_e_stage", stage, 2);
    tick();
    check("hr_wb_stage", stage, 4);
    check("hr_wb_halted", halted, 0);
    check("hr_wb_pc_en", pc_en, 1);
    tick();
    check("hr_stage", stage, 7);
    check("hr_fault", fault, 0);
    check("hr_halted", halted, 1);
    check("hr_retired", retired, 1);
    $display("[TB] halt request at boundary checked");

    // Async reset in the middle of a STORE wait
    halt_req = 1'b0; resume = 1'b1;
    tick();
    resume = 1'b0; opcode = 7'h23; #1;
    check("rm_f_stage", stage, 0);
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    check("rm_m_stage", stage, 3);
    check("rm_m_mem_we", mem_we, 1);
    rst = 1'b0; #1;
    check("rm_mem_req", mem_req, 0);
    check("rm_mem_we", mem_we, 0);
    check("rm_pc_en", pc_en, 0);
    check("rm_stage", stage, 0);
    check("rm_retired", retired, 0);
    rst = 1'b1;
    $display("[TB] reset mid-store checked");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Next-generation replacement for the fixed-rotation stage counter plus per-unit stage decode in the multi-cycle RV32I core.
- Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK per opcode class, with optional MEMORY skip.
- Stalls on a memory ready handshake, times out stuck accesses, halts on faults or a debug request, and counts retired instructions.
- Sits between the decoder and memory outputs and the IR, PC, register file and memory write enables.

Parameters:
- SKIP_MEM, 1, 1: non-load/store instructions bypass MEMORY. 0: every instruction visits all five stages (legacy timing).
- TIMEOUT_W, 4, width of the memory wait counter.
- MEM_TIMEOUT, 15, wait cycles allowed before a timeout fault. Must be less than 2**TIMEOUT_W.
- RETIRE_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous reset, active low
- opcode  input  7  decoded opcode of the current IR
- instr_valid  input  1  decoder legality flag
- mem_ready  input  1  memory has data/accepted write this cycle
- illegal_read_address  input  1  from memory
- illegal_write_address  input  1  from memory
- halt_req  input  1  debug halt request, level
- resume  input  1  leave HALT, one-cycle pulse
- stage  output  3  0 FETCH, 1 DECODE, 2 EXECUTE, 3 MEMORY, 4 WRITEBACK, 7 HALT
- ir_en  output  1  instruction register load
- pc_en  output  1  PC register load
- reg_wr_en  output  1  register file write
- mem_req  output  1  memory access active
- mem_we  output  1  store write enable
- halted  output  1  stage==HALT
- fault  output  2  0 none, 1 illegal instr, 2 bad address, 3 timeout
- retired  output  RETIRE_W  retired instruction count

Behaviour:
- Reset (rst low, async): stage=FETCH, wait counter=0, fault=0, retired=0.
- Registered state: stage, wait counter, fault, retired.
- Combinational decode of stage: ir_en, pc_en, reg_wr_en, mem_req, mem_we. All are 0 while rst is low.
- Opcode classes:
  - LOAD 0000011, STORE 0100011.
  - WB-writers: OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
  - BRANCH 1100011.
  - Any other opcode is treated as no-writeback.
- FETCH:
  - mem_req=1.
  - If mem_ready=0, stay and increment the wait counter.
  - If mem_ready=1 and illegal_read_address=1: fault=2, go to HALT, ir_en=0.
  - If mem_ready=1 otherwise: ir_en=1 and go to DECODE.
  - The wait counter clears on every stage change.
- DECODE: always one cycle. If instr_valid=0, fault=1 and go to HALT. Otherwise go to EXECUTE.
- EXECUTE: always one cycle.
  - Goes to MEMORY if the class is LOAD/STORE, or if SKIP_MEM=0.
  - Otherwise goes to WRITEBACK.
- MEMORY:
  - mem_req=1 for LOAD/STORE only. For other classes it is a one-cycle pass-through and mem_ready is ignored.
  - mem_we=1 for STORE, and is held through the whole wait.
  - Waits on mem_ready exactly as in FETCH.
  - On mem_ready, an illegal address raises fault=2 and goes to HALT. The address flag checked is illegal_write_address for STORE and illegal_read_address for LOAD.
  - STORE completes here: pc_en=1 in the mem_ready cycle, then the instruction boundary.
  - Otherwise the next stage is WRITEBACK.
- WRITEBACK: one cycle. pc_en=1. reg_wr_en=1 for LOAD and WB-writers. This cycle is the boundary.
- Timeout: if the wait counter equals MEM_TIMEOUT while mem_ready=0, then fault=3 and go to HALT next cycle. Total wait cycles before HALT = MEM_TIMEOUT+1.
- Faulting instructions never assert pc_en or reg_wr_en. The PC still points at the faulting instruction.
- Boundary: the cycle after pc_en.
  - If halt_req=1 in the pc_en cycle, go to HALT with fault unchanged (0).
  - Otherwise go to FETCH.
  - halt_req in any other cycle is ignored until the next boundary.
- Retired count: retired increments on every pc_en cycle and wraps to 0 at max.
- HALT:
  - All enables are 0.
  - On resume=1, go to FETCH and clear fault. resume outside HALT is ignored.
  - If halt_req and resume are both 1 in HALT, resume wins. halt_req is re-evaluated at the next boundary.
- Reset mid-access: mem_req drops immediately (async). No partial store is committed by this block.

Test Plan:
- OP-IMM (0x13), mem_ready=1 always, SKIP_MEM=1:
  - Stages 0,1,2,4,0.
  - pc_en and reg_wr_en high in the stage-4 cycle.
  - retired 0->1 after 4 cycles.
- Same, SKIP_MEM=0: stages 0,1,2,3,4. MEMORY has mem_req=0. retired=1 after 5 cycles.
- STORE (0x23), mem_ready low 3 cycles in MEMORY:
  - mem_req and mem_we held 4 cycles.
  - pc_en in the 4th cycle, reg_wr_en never asserted.
  - Next stage 0.
- FETCH with mem_ready stuck 0, MEM_TIMEOUT=15: stage=7 and fault=3 after 16 wait cycles. Then resume: stage=0, fault=0, retired unchanged.
- DECODE with instr_valid=0: stage=7, fault=1, pc_en never asserted.
- LOAD (0x03) with illegal_read_address=1 at mem_ready: stage=7, fault=2, no reg_wr_en.
- halt_req raised during EXECUTE of an OP: halt_req is ignored until WRITEBACK, then stage=7, fault=0, halted=1.
- rst asserted low mid-MEMORY of a store: outputs immediately idle, stage=0, retired=0.
